// File: rtl/md5crypt_pkg.sv
// Shared definitions for the md5crypt unit array: default sizing and the
// dispatch scheduler state encoding.
package md5crypt_pkg;

  localparam int MD5_N_UNITS     = 16;
  localparam int MD5_UNIT_ID_W   = 4;
  localparam int MD5_MAX_KEY_LEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PICK = 2'd1,
    ST_XFER = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or after ptr,
// scanning upward and wrapping. Shared by dispatch and result collection.
module rr_arbiter #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  // Scan from the far end down so the nearest candidate to ptr is written last.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/md5crypt_unit_sched.sv
// Hands complete keys from the word buffer to idle md5crypt units, one
// 32-bit beat per cycle, and reports aggregate idle status and dispatch count.
module md5crypt_unit_sched
  import md5crypt_pkg::*;
#(
  parameter int N_UNITS     = MD5_N_UNITS,
  parameter int UNIT_ID_W   = MD5_UNIT_ID_W,
  parameter int MAX_KEY_LEN = MD5_MAX_KEY_LEN
) (
  input  logic                 CORE_CLK,
  input  logic                 rst,
  input  logic [N_UNITS-1:0]   unit_mask,
  input  logic                 word_valid,
  input  logic [5:0]           word_len,
  output logic                 word_ready,
  input  logic [N_UNITS-1:0]   unit_idle,
  output logic                 beat_en,
  output logic [2:0]           beat_idx,
  output logic [N_UNITS-1:0]   unit_wr_en,
  output logic                 unit_last,
  output logic [UNIT_ID_W-1:0] unit_sel,
  output logic                 cores_idle,
  output logic                 err_no_units,
  output logic [31:0]          dispatched_cnt
);

  localparam logic [6:0] MAX_LEN7 = 7'(MAX_KEY_LEN);

  sched_state_e         state_q, state_d;
  logic [N_UNITS-1:0]   mask_q, mask_d;
  logic [N_UNITS-1:0]   reserved_q, reserved_d;
  logic [N_UNITS-1:0]   wr_en_q, wr_en_d;
  logic [UNIT_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [UNIT_ID_W-1:0] sel_q, sel_d;
  logic [2:0]           beat_idx_q, beat_idx_d;
  logic [2:0]           last_idx_q, last_idx_d;
  logic                 beat_en_q, beat_en_d;
  logic                 last_q, last_d;
  logic                 cores_idle_q, cores_idle_d;
  logic                 err_q, err_d;
  logic [31:0]          cnt_q, cnt_d;

  logic [N_UNITS-1:0]   eligible;
  logic [UNIT_ID_W-1:0] gnt_idx;
  logic                 gnt_vld;
  logic [6:0]           len_c;
  logic [6:0]           nbeats;

  // A granted unit stays reserved until it is seen dropping idle.
  assign eligible = unit_idle & ~mask_q & ~reserved_q;

  rr_arbiter #(
    .N     (N_UNITS),
    .IDX_W (UNIT_ID_W)
  ) u_arb (
    .req     (eligible),
    .ptr     (rr_ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign len_c  = ({1'b0, word_len} > MAX_LEN7) ? MAX_LEN7 : {1'b0, word_len};
  assign nbeats = (len_c == 7'd0) ? 7'd1 : ((len_c + 7'd3) >> 2);

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    reserved_d   = reserved_q & unit_idle;
    rr_ptr_d     = rr_ptr_q;
    sel_d        = sel_q;
    beat_idx_d   = beat_idx_q;
    last_idx_d   = last_idx_q;
    beat_en_d    = 1'b0;
    wr_en_d      = '0;
    last_d       = 1'b0;
    err_d        = err_q;
    cnt_d        = cnt_q;
    cores_idle_d = (state_q == ST_IDLE) && !word_valid && (reserved_q == '0) &&
                   (&(unit_idle | mask_q));

    case (state_q)
      ST_IDLE: begin
        mask_d = unit_mask;
        if (word_valid) begin
          if (&mask_q) err_d = 1'b1;
          else         state_d = ST_PICK;
        end
      end
      ST_PICK: begin
        if (gnt_vld) begin
          sel_d               = gnt_idx;
          reserved_d[gnt_idx] = 1'b1;
          rr_ptr_d            = (int'(gnt_idx) == N_UNITS - 1) ? '0 : gnt_idx + UNIT_ID_W'(1);
          last_idx_d          = 3'(nbeats - 7'd1);
          beat_idx_d          = 3'd0;
          beat_en_d           = 1'b1;
          wr_en_d             = {{(N_UNITS-1){1'b0}}, 1'b1} << gnt_idx;
          last_d              = (nbeats == 7'd1);
          state_d             = ST_XFER;
        end
      end
      ST_XFER: begin
        if (beat_idx_q == last_idx_q) begin
          cnt_d      = cnt_q + 32'd1;
          beat_idx_d = 3'd0;
          state_d    = ST_IDLE;
        end else begin
          beat_idx_d = beat_idx_q + 3'd1;
          beat_en_d  = 1'b1;
          wr_en_d    = wr_en_q;
          last_d     = ((beat_idx_q + 3'd1) == last_idx_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CORE_CLK) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      reserved_q   <= '0;
      rr_ptr_q     <= '0;
      sel_q        <= '0;
      beat_idx_q   <= '0;
      last_idx_q   <= '0;
      beat_en_q    <= 1'b0;
      wr_en_q      <= '0;
      last_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      cores_idle_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      reserved_q   <= reserved_d;
      rr_ptr_q     <= rr_ptr_d;
      sel_q        <= sel_d;
      beat_idx_q   <= beat_idx_d;
      last_idx_q   <= last_idx_d;
      beat_en_q    <= beat_en_d;
      wr_en_q      <= wr_en_d;
      last_q       <= last_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      cores_idle_q <= cores_idle_d;
    end
  end

  // Acceptance is visible in the PICK cycle itself so the buffer sees it at t+1.
  assign word_ready     = (state_q == ST_PICK) && gnt_vld;
  assign beat_en        = beat_en_q;
  assign beat_idx       = beat_idx_q;
  assign unit_wr_en     = wr_en_q;
  assign unit_last      = last_q;
  assign unit_sel       = sel_q;
  assign cores_idle     = cores_idle_q;
  assign err_no_units   = err_q;
  assign dispatched_cnt = cnt_q;

endmodule

// File: tb/tb_md5crypt_unit_sched.sv
// Self-checking bench: bench-side unit models plus a transaction-level
// scheduler model (round-robin pointer, reservations, key beat counts).
module tb_md5crypt_unit_sched;

  localparam int N = 16;

  logic          CORE_CLK = 1'b0;
  logic          rst;
  logic [N-1:0]  unit_mask;
  logic          word_valid;
  logic [5:0]    word_len;
  logic          word_ready;
  logic [N-1:0]  unit_idle;
  logic          beat_en;
  logic [2:0]    beat_idx;
  logic [N-1:0]  unit_wr_en;
  logic          unit_last;
  logic [3:0]    unit_sel;
  logic          cores_idle;
  logic          err_no_units;
  logic [31:0]   dispatched_cnt;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  int cnt_m  = 0;
  logic [N-1:0] res_m;
  int timer [N];

  always #5 CORE_CLK = ~CORE_CLK;

  md5crypt_unit_sched #(.N_UNITS(16), .UNIT_ID_W(4), .MAX_KEY_LEN(32)) dut (
    .CORE_CLK       (CORE_CLK),
    .rst            (rst),
    .unit_mask      (unit_mask),
    .word_valid     (word_valid),
    .word_len       (word_len),
    .word_ready     (word_ready),
    .unit_idle      (unit_idle),
    .beat_en        (beat_en),
    .beat_idx       (beat_idx),
    .unit_wr_en     (unit_wr_en),
    .unit_last      (unit_last),
    .unit_sel       (unit_sel),
    .cores_idle     (cores_idle),
    .err_no_units   (err_no_units),
    .dispatched_cnt (dispatched_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] elig, input int p);
    for (int k = 0; k < N; k++)
      if (elig[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int key_beats(input int len);
    int l;
    int b;
    l = (len > 32) ? 32 : len;
    b = (l + 3) / 4;
    return (b == 0) ? 1 : b;
  endfunction

  // One clock: record what the DUT sampled, then advance the unit models.
  task automatic step();
    logic [N-1:0] seen;
    @(posedge CORE_CLK);
    seen = unit_idle;
    #1;
    res_m = rst ? '0 : (res_m & seen);
    for (int i = 0; i < N; i++) begin
      if (timer[i] > 0) begin
        timer[i]--;
        if (timer[i] == 0) unit_idle[i] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    word_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    ptr_m = 0;
    cnt_m = 0;
    res_m = '0;
  endtask

  task automatic units_all_idle();
    unit_idle = '1;
    for (int i = 0; i < N; i++) timer[i] = 0;
  endtask

  task automatic do_key(input int len, input bit drop, output int waited, output int sel);
    bit got;
    int exp;
    int nb;
    word_len   = 6'(len);
    word_valid = 1'b1;
    waited = 0;
    got    = 1'b0;
    sel    = -1;
    while (!got && waited < 200) begin
      step();
      waited++;
      got = word_ready;
    end
    chk("word_ready_seen", 32'(got), 32'd1);
    word_valid = 1'b0;
    if (!got) return;
    exp = pick(unit_idle & ~unit_mask & ~res_m, ptr_m);
    chk("grant_expected", 32'(exp >= 0), 32'd1);
    if (exp < 0) begin
      for (int i = 0; i < 10; i++) step();
      return;
    end
    nb = key_beats(len);
    step();
    res_m[exp] = 1'b1;
    sel = int'(unit_sel);
    for (int b = 0; b < nb; b++) begin
      chk("beat_en", 32'(beat_en), 32'd1);
      chk("beat_idx", 32'(beat_idx), 32'(b));
      chk("unit_sel", 32'(unit_sel), 32'(exp));
      chk("unit_wr_en", 32'(unit_wr_en), 32'd1 << exp);
      chk("unit_last", 32'(unit_last), 32'(b == nb - 1));
      if (b == 0 && drop) begin
        unit_idle[exp] = 1'b0;
        timer[exp] = $urandom_range(1, 8);
      end
      step();
    end
    chk("beat_done", 32'(beat_en), 32'd0);
    cnt_m++;
    chk("dispatched_cnt", dispatched_cnt, 32'(cnt_m));
    ptr_m = (exp + 1) % N;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    int s;
    int excl_list [6];
    excl_list = '{1, 2, 3, 4, 5, 8};

    rst = 1'b1;
    unit_mask = '0;
    word_valid = 1'b0;
    word_len = '0;
    res_m = '0;
    units_all_idle();
    step();
    step();
    chk("rst_beat_en", 32'(beat_en), 0);
    chk("rst_wr_en", 32'(unit_wr_en), 0);
    chk("rst_last", 32'(unit_last), 0);
    chk("rst_sel", 32'(unit_sel), 0);
    chk("rst_beat_idx", 32'(beat_idx), 0);
    chk("rst_cnt", dispatched_cnt, 0);
    chk("rst_err", 32'(err_no_units), 0);
    chk("rst_cores_idle", 32'(cores_idle), 0);
    chk("rst_word_ready", 32'(word_ready), 0);
    rst = 1'b0;
    step();
    chk("cores_idle_after_rst", 32'(cores_idle), 1);

    // Reset in the middle of a long key: strobes drop, nothing counted,
    // unit 0 stays idle so a stale reservation would show up next.
    word_len = 6'd32;
    word_valid = 1'b1;
    step();
    chk("abort_ready", 32'(word_ready), 1);
    word_valid = 1'b0;
    step();
    step();
    step();
    chk("abort_mid_idx", 32'(beat_idx), 2);
    rst = 1'b1;
    step();
    chk("abort_beat_en", 32'(beat_en), 0);
    chk("abort_wr_en", 32'(unit_wr_en), 0);
    chk("abort_cnt", dispatched_cnt, 0);
    rst = 1'b0;
    ptr_m = 0;
    cnt_m = 0;
    res_m = '0;

    do_key(3, 1'b1, w, s);
    chk("single_latency", 32'(w), 1);
    chk("single_unit", 32'(s), 0);
    do_key(32, 1'b1, w, s);
    do_key(0, 1'b1, w, s);
    do_key(40, 1'b1, w, s);

    // Back-to-back keys with all units enabled: pointer walks and wraps.
    for (int k = 0; k < 20; k++) begin
      do_key($urandom_range(0, 32), 1'b1, w, s);
      chk("rr_latency", 32'(w), 1);
    end

    // Random masks, lengths and gaps.
    for (int k = 0; k < 40; k++) begin
      if (k % 8 == 0) begin
        unit_mask = 16'($urandom);
        if (&unit_mask) unit_mask[k % N] = 1'b0;
        step();
      end
      repeat ($urandom_range(0, 2)) step();
      do_key($urandom_range(0, 40), 1'b1, w, s);
    end

    do_reset();
    units_all_idle();
    unit_mask = 16'h10C1;
    step();
    for (int k = 0; k < 6; k++) begin
      do_key($urandom_range(0, 32), 1'b1, w, s);
      chk("excl_grant", 32'(s), 32'(excl_list[k]));
    end

    // Every unit busy: unit 9 comes back before unit 3.
    do_reset();
    units_all_idle();
    unit_mask = '0;
    unit_idle = '0;
    timer[9] = 5;
    timer[3] = 9;
    step();
    chk("busy_cores_idle", 32'(cores_idle), 0);
    do_key(8, 1'b1, w, s);
    chk("busy_unit", 32'(s), 9);
    chk("busy_wait", 32'(w), 4);

    units_all_idle();
    unit_mask = '0;
    repeat (3) step();
    chk("cores_idle_all", 32'(cores_idle), 1);
    unit_idle[5] = 1'b0;
    step();
    step();
    chk("cores_idle_busy", 32'(cores_idle), 0);
    unit_mask[5] = 1'b1;
    step();
    step();
    chk("cores_idle_masked", 32'(cores_idle), 1);
    unit_idle[5] = 1'b1;
    unit_mask = '0;
    step();

    chk("err_before", 32'(err_no_units), 0);
    unit_mask = '1;
    step();
    word_len = 6'd4;
    word_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("nounit_ready", 32'(word_ready), 0);
      chk("nounit_beat", 32'(beat_en), 0);
    end
    chk("err_set", 32'(err_no_units), 1);
    word_valid = 1'b0;
    unit_mask = '0;
    step();
    step();
    chk("err_sticky", 32'(err_no_units), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
